freq_meter: RTL
===============

// Module: freq_meter
// PURPOSE
// Reciprocal of the DDS output path: measures the frequency of an external square wave
// (DDS output via comparator, or any test signal) by counting rising edges over a fixed gate.
// Converts the count to 6-digit packed BCD in the same format as the keypad frequency word,
// so it can drive the 6-digit 7-segment scanner directly or be compared against the setpoint.
// PARAMETERS
// CLK_HZ       50_000_000  clkin frequency in Hz (documentation / default derivation only)
// GATE_CYCLES  CLK_HZ      clkin cycles per gate window (1 s gate -> count in Hz); >= 2
// MAX_COUNT    999_999     saturation value; largest 6-digit BCD result
// PORTS
// clkin     in   1   system clock, all logic on posedge
// rst_n     in   1   asynchronous active-low reset
// sig_in    in   1   measured signal, asynchronous to clkin
// meas_en   in   1   level: 1 = measure continuously, 0 = stop/abort
// bcd_out   out  24  last result, packed BCD, [23:20] = most significant digit
// valid     out  1   1-cycle pulse when bcd_out updates
// overflow  out  1   last result saturated at MAX_COUNT; updates with bcd_out
// busy      out  1   1 in GATE or CONV
// BEHAVIOUR
// - Reset: bcd_out=24'h000000, valid=0, overflow=0, busy=0, state=IDLE, counters 0, sync FFs 0.
// - sig_in: 2-FF synchronizer + 3rd FF for edge detect; rise = s2 & ~s3 (3-cycle input latency).
// - Input spec: high and low phases each >= 2 clkin cycles; narrower pulses may be missed.
// - FSM IDLE -> GATE -> CONV -> DONE:
//   IDLE: meas_en=1 -> GATE; clear gate_cnt and edge_cnt.
//   GATE: gate_cnt counts 0..GATE_CYCLES-1; every rise increments edge_cnt (20 bit),
//         saturating at MAX_COUNT, sticky ovf flag set on attempt to exceed it.
//         Last gate cycle (gate_cnt==GATE_CYCLES-1): its rise IS counted, then -> CONV.
//         Rises seen in the cycle after the gate closes are NOT counted.
//   CONV: sequential double-dabble, 20 shift iterations, 1 per cycle (add-3 on digits >=5
//         before each shift); exactly 20 cycles in CONV.
//   DONE: 1 cycle: bcd_out<=converted value, overflow<=ovf, valid=1;
//         meas_en=1 -> GATE directly (counters cleared, no gap beyond this cycle); else IDLE.
// - Latency gate close -> valid: 21 cycles. Period meas_en-rise -> first valid: GATE_CYCLES+22.
// - meas_en=0 during GATE or CONV: abort to IDLE next cycle; bcd_out/overflow retained, no valid.
// - meas_en=0 in DONE: the update and valid pulse still occur, then IDLE.
// - bcd_out/overflow hold between valid pulses; never show partial conversion.
// - Async reset mid-GATE/CONV: immediate return to reset values; no valid afterward.
// - edge_cnt 20 bits (2^20 > 999_999); gate_cnt width $clog2(GATE_CYCLES).
// - busy = (state==GATE)||(state==CONV).
// STRUCTURE
// - Shared package freq_meter_pkg: state typedef {IDLE,GATE,CONV,DONE}, BCD_DIGITS=6,
//   BIN_W=20, BCD_W=24 constants; reused by display scanner and keypad entry blocks.
// - One sub-module: bin2bcd_seq (start/bin[19:0] in, done/bcd[23:0] out, 20-cycle
//   iterative double-dabble); FSM, synchronizer, gate and edge counters stay in freq_meter.
// TESTING  (sim: GATE_CYCLES=1000)
// - Reset: assert rst_n=0 mid-GATE -> all outputs 0 immediately; release, meas_en=0 -> stays IDLE.
// - sig_in period 10 clk, meas_en=1 -> valid after 1022 cycles, bcd_out=24'h000100, overflow=0.
// - sig_in held 0 -> bcd_out=24'h000000; sig_in period 4 clk -> 24'h000250.
// - Back-to-back: meas_en held 1 across 3 gates -> valid pulses exactly 1021 cycles apart.
// - Overflow: force edge_cnt near MAX_COUNT (or GATE_CYCLES=2_100_000, period 2) ->
//   bcd_out=24'h999999, overflow=1; next normal gate clears overflow to 0.
// - Abort/boundary: drop meas_en at gate_cnt=500 -> no valid, bcd_out unchanged; single rise
//   in last gate cycle counted (+1), rise one cycle later not counted.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter, display scanner and keypad entry.
// Also hosts the double-dabble digit adjust step used by the iterative converter.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        CONV = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned BCD_DIGITS  = 6;
    localparam int unsigned BIN_W       = 20;
    localparam int unsigned BCD_W       = 4 * BCD_DIGITS;
    localparam int unsigned CONV_CYCLES = BIN_W;
    localparam int unsigned CONV_CNT_W  = $clog2(CONV_CYCLES);

    // Add 3 to every BCD digit >= 5 so the following left shift carries correctly.
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] r;
        r = bcd;
        for (int i = 0; i < int'(BCD_DIGITS); i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: one adjust+shift per cycle, BIN_W cycles per conversion.
// The first iteration happens on the start cycle; done pulses once the result is final.
module bin2bcd_seq
    import freq_meter_pkg::*;
(
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    localparam int unsigned SR_W = BCD_W + BIN_W;

    logic [SR_W-1:0]       sreg_q;
    logic [SR_W-1:0]       src_c;
    logic [SR_W-1:0]       step_c;
    logic [CONV_CNT_W-1:0] iter_q;
    logic                  busy_q;
    logic                  done_q;

    // One double-dabble step; start seeds the shift register with the binary input.
    always_comb begin
        src_c  = start ? {BCD_W'(0), bin} : sreg_q;
        step_c = {bcd_adjust(src_c[SR_W-1 -: BCD_W]), src_c[BIN_W-1:0]} << 1;
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q <= '0;
            iter_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                sreg_q <= step_c;
                iter_q <= CONV_CNT_W'(1);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                sreg_q <= step_c;
                iter_q <= iter_q + CONV_CNT_W'(1);
                if (iter_q == CONV_CNT_W'(CONV_CYCLES - 1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done = done_q;
    assign bcd  = sreg_q[SR_W-1 -: BCD_W];

endmodule

// File: rtl/freq_meter.sv
// Gated rising-edge counter for an asynchronous input, with saturating count and
// sequential BCD conversion; result format matches the keypad frequency word.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned GATE_CYCLES = CLK_HZ,
    parameter int unsigned MAX_COUNT   = 999_999
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             meas_en,
    output logic [BCD_W-1:0] bcd_out,
    output logic             valid,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [BIN_W-1:0]  MAX_BIN   = BIN_W'(MAX_COUNT);
    localparam logic [CONV_CNT_W-1:0] CONV_LAST = CONV_CNT_W'(CONV_CYCLES - 1);

    state_t                state_q;
    state_t                state_c;
    logic                  s1_q, s2_q, s3_q;
    logic                  rise_c;
    logic [GATE_W-1:0]     gate_cnt_q;
    logic [BIN_W-1:0]      edge_cnt_q;
    logic                  ovf_q;
    logic [CONV_CNT_W-1:0] conv_cnt_q;
    logic                  gate_last_c;
    logic                  clear_c;
    logic                  count_c;
    logic                  conv_start_c;
    logic                  load_c;
    logic                  busy_c;
    logic                  conv_done;
    logic [BCD_W-1:0]      conv_bcd;

    // Two-flop synchronizer plus a third flop for rising-edge detection.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sig_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_c      = s2_q & ~s3_q;
    assign gate_last_c = (gate_cnt_q == GATE_LAST);

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_c;
        end
    end

    // Dropping meas_en aborts a gate or conversion; DONE always completes its update.
    always_comb begin
        state_c = state_q;
        case (state_q)
            IDLE: if (meas_en) state_c = GATE;
            GATE: begin
                if (!meas_en)         state_c = IDLE;
                else if (gate_last_c) state_c = CONV;
            end
            CONV: begin
                if (!meas_en)                     state_c = IDLE;
                else if (conv_cnt_q == CONV_LAST) state_c = DONE;
            end
            DONE:    state_c = meas_en ? GATE : IDLE;
            default: state_c = IDLE;
        endcase
    end

    always_comb begin
        clear_c      = (state_c == GATE) && (state_q != GATE);
        count_c      = (state_q == GATE);
        conv_start_c = (state_q == CONV) && (conv_cnt_q == '0);
        load_c       = (state_q == DONE) && conv_done;
        busy_c       = (state_c == GATE) || (state_c == CONV);
    end

    // Gate timing, saturating edge count and conversion cycle count.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            ovf_q      <= 1'b0;
            conv_cnt_q <= '0;
        end else begin
            if (clear_c) begin
                gate_cnt_q <= '0;
                edge_cnt_q <= '0;
                ovf_q      <= 1'b0;
            end else if (count_c) begin
                gate_cnt_q <= gate_cnt_q + GATE_W'(1);
                if (rise_c) begin
                    if (edge_cnt_q >= MAX_BIN) ovf_q <= 1'b1;
                    else                       edge_cnt_q <= edge_cnt_q + BIN_W'(1);
                end
            end
            conv_cnt_q <= (state_q == CONV) ? conv_cnt_q + CONV_CNT_W'(1) : '0;
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clkin (clkin),
        .rst_n (rst_n),
        .start (conv_start_c),
        .bin   (edge_cnt_q),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Result registers only change on a completed conversion.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            bcd_out  <= '0;
            overflow <= 1'b0;
            valid    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            valid <= load_c;
            busy  <= busy_c;
            if (load_c) begin
                bcd_out  <= conv_bcd;
                overflow <= ovf_q;
            end
        end
    end

endmodule
